pipelined_mac_pe: RTL and testbench
===================================

Name: pipelined_mac_pe

Overview:
Second-generation systolic processing element for the TPU array: a sign-magnitude fixed-point multiply-accumulate cell with parametrised N/Q.
- x/y operands are forwarded to neighbours one cycle after capture.
- Internal 2-stage pipeline (multiply, then accumulate) sustains one MAC per cycle.
- Adds saturation with a sticky overflow flag, synchronous accumulator clear, and a valid output for downstream cells.

Parameters:
N, 32, total word width; bit N-1 is sign, bits N-2:0 are magnitude
Q, 10, fractional bits of the magnitude (N-1-Q integer bits); must satisfy 0 <= Q < N-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  operand valid; x_in/y_in sampled when high
clr  in  1  synchronous clear of accumulator and overflow flag
x_in  in  N  sign-magnitude operand from west neighbour
y_in  in  N  sign-magnitude operand from north neighbour
x_out  out  N  registered x_in, to east neighbour
y_out  out  N  registered y_in, to south neighbour
vld_out  out  1  registered en, accompanies x_out/y_out
acc_sum  out  N  sign-magnitude accumulator value
ovf  out  1  sticky saturation flag

Behaviour:
- Reset (rst_n low, asynchronous): x_out=0, y_out=0, vld_out=0, acc_sum=0, ovf=0, and the product pipeline register and its valid bit are cleared.
- Format: sign-magnitude throughout. Negative zero is accepted on inputs. A zero result is always stored with sign 0.
- Stage 0 (edge where en=1):
  - x_out<=x_in, y_out<=y_in, vld_out<=1.
  - Product register <= sign (x[N-1]^y[N-1]) and magnitude (|x|*|y|) >> Q, truncated toward zero.
  - Product valid <= 1.
- Edge where en=0: x_out/y_out hold, vld_out<=0, product valid<=0.
- Stage 1 (edge where product valid=1): acc <= acc + product, using sign-magnitude add:
  - Same signs: add the magnitudes.
  - Different signs: subtract the smaller magnitude from the larger; result takes the sign of the larger.
  - Equal magnitudes: +0.
- Latency:
  - x_out/y_out/vld_out: 1 cycle after sample.
  - acc_sum: reflects the sample 2 edges after en.
  - Back-to-back en gives one accumulation per cycle with no bubbles.
- Saturation:
  - A product magnitude exceeding 2^(N-1)-1 clamps to 2^(N-1)-1 and sets ovf.
  - An accumulate magnitude exceeding 2^(N-1)-1 clamps to 2^(N-1)-1, keeps its sign, and sets ovf.
  - ovf stays high until clr or reset.
- clr:
  - Zeroes acc and ovf on that edge.
  - Does not flush the product register. A product already in flight at the clr edge is discarded.
  - A sample taken on the same edge as clr (en=1) proceeds normally and becomes the first term of the new sum.
  - x/y forwarding is unaffected by clr.
- Reset mid-pipeline discards all in-flight products; no partial update.

Optional Feature:
PE_ROUND_EN
- Defined: the product magnitude is rounded half-up at bit Q-1 (add 2^(Q-1) before the shift); saturation is still applied after rounding.
- Undefined: truncation toward zero as above. Ports and latency are identical in both builds.

Decomposition:
- Package pe_pkg holds:
  - Localparams MAG_W=N-1 and MAG_MAX.
  - Functions sm_add (sign-magnitude add with saturate flag) and sm_norm (negative zero to +0).
- One sub-module, sm_multiplier: combinational sign-magnitude multiply with shift, rounding/truncation and saturate flag.
- The PE instantiates sm_multiplier and registers its output.

Test Plan:
- Reset then en pulses with (1,2),(3,2),(5,5),(7,4) in integer Q10 -> acc_sum = 2,8,33,61 (61 = 0x0000F400); x_out/y_out echo each input one cycle later.
- clr, then (5,8),(2,3),(-3,4),(-2,-2) -> acc 40,46,34,38.
- clr, then (-1,-1),(5,-8),(2,-3),(5,10) -> acc +1,-39,-45,+5.
- Fraction cases:
  - 0.5*0.5 -> 0x00000100.
  - 0.25*1.5 accumulated -> 0.625 (0x00000280).
  - Truncation vs PE_ROUND_EN: x=0x00000001 (2^-10), y=0x00000200 (0.5) -> product 0 truncated, 1 LSB rounded.
- Saturation/sign:
  - x=0x7FFFFFFF, y=2.0 -> acc_sum=0x7FFFFFFF, ovf=1, ovf held on later en cycles until clr.
  - (3,2) then (-3,2) -> acc 0x00000000 (not 0x80000000).
- Pipeline/clr:
  - en held 4 consecutive cycles with (1,2),(3,2),(5,5),(7,4) -> acc 2,8,33,61 on consecutive edges starting 2 edges after first sample.
  - clr asserted with en on the third sample -> acc ends 25+28=53.
  - rst_n asserted asynchronously mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, limits and sign-magnitude helpers for the systolic MAC processing element.
// Helpers operate on a 64-bit working magnitude, so N may be at most 64.
package pe_pkg;

    localparam int N_DEF = 32;
    localparam int Q_DEF = 10;
    localparam int MAG_W = N_DEF - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;
    localparam int SM_W = 64;

    typedef struct packed {
        logic            sign;
        logic [SM_W-1:0] mag;
        logic            sat;
    } sm_sum_t;

    function automatic logic sm_norm(input logic sign, input logic [SM_W-1:0] mag);
        return sign & (|mag);
    endfunction

    // Both operand magnitudes must already be <= mag_max (< 2^63), so the raw sum cannot wrap.
    function automatic sm_sum_t sm_add(input logic            a_sign,
                                       input logic [SM_W-1:0] a_mag,
                                       input logic            b_sign,
                                       input logic [SM_W-1:0] b_mag,
                                       input logic [SM_W-1:0] mag_max);
        sm_sum_t r;
        r = '0;
        if (a_sign == b_sign) begin
            r.sign = a_sign;
            r.mag  = a_mag + b_mag;
        end else if (a_mag >= b_mag) begin
            r.sign = a_sign;
            r.mag  = a_mag - b_mag;
        end else begin
            r.sign = b_sign;
            r.mag  = b_mag - a_mag;
        end
        if (r.mag > mag_max) begin
            r.mag = mag_max;
            r.sat = 1'b1;
        end
        r.sign = sm_norm(r.sign, r.mag);
        return r;
    endfunction

endpackage

// File: rtl/pipelined_mac_pe_if.sv
// Operand/result bundle of one systolic PE; master is the array side, slave is the PE.
interface pipelined_mac_pe_if #(parameter int N = 32);

    logic         en;
    logic         clr;
    logic [N-1:0] x_in;
    logic [N-1:0] y_in;
    logic [N-1:0] x_out;
    logic [N-1:0] y_out;
    logic         vld_out;
    logic [N-1:0] acc_sum;
    logic         ovf;

    modport master (
        output en, clr, x_in, y_in,
        input  x_out, y_out, vld_out, acc_sum, ovf
    );

    modport slave (
        input  en, clr, x_in, y_in,
        output x_out, y_out, vld_out, acc_sum, ovf
    );

endinterface

// File: rtl/pipelined_mac_pe_sm_multiplier.sv
// Combinational sign-magnitude Q-format multiply with saturation.
// Build macro PE_ROUND_EN selects round-half-up instead of truncation toward zero.
module sm_multiplier
    import pe_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         p_sign,
    output logic [N-2:0] p_mag,
    output logic         p_sat
);

    localparam int MW = N - 1;
    // One spare bit above the full product absorbs the rounding carry.
    localparam int PW = 2 * MW + 1;

`ifdef PE_ROUND_EN
    localparam logic [PW-1:0] RND_INC = (Q > 0) ? (PW'(1) << ((Q > 0) ? Q - 1 : 0)) : '0;
`else
    localparam logic [PW-1:0] RND_INC = '0;
`endif
    localparam logic [PW-1:0] MAX_EXT = PW'({MW{1'b1}});

    logic [PW-1:0] prod;
    logic [PW-1:0] scaled;

    always_comb begin
        prod   = PW'(a[MW-1:0]) * PW'(b[MW-1:0]) + RND_INC;
        scaled = prod >> Q;
        p_sat  = scaled > MAX_EXT;
        p_mag  = p_sat ? {MW{1'b1}} : scaled[MW-1:0];
        p_sign = sm_norm(a[N-1] ^ b[N-1], SM_W'(p_mag));
    end

endmodule

// File: rtl/pipelined_mac_pe.sv
// Systolic sign-magnitude MAC cell: forwards x/y east/south, multiplies, then accumulates with saturation.
// Rounding of the product is selected at build time by PE_ROUND_EN (see sm_multiplier).
module pipelined_mac_pe
    import pe_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_mac_pe_if.slave pe
);

    localparam int MW = N - 1;
    localparam logic [SM_W-1:0] MAX_SM = SM_W'({MW{1'b1}});

    logic [N-1:0]  x_out_q, x_out_d;
    logic [N-1:0]  y_out_q, y_out_d;
    logic          vld_q, vld_d;
    logic          p_vld_q, p_vld_d;
    logic          p_sign_q, p_sign_d;
    logic [MW-1:0] p_mag_q, p_mag_d;
    logic          p_sat_q, p_sat_d;
    logic          acc_sign_q, acc_sign_d;
    logic [MW-1:0] acc_mag_q, acc_mag_d;
    logic          ovf_q, ovf_d;

    logic          m_sign;
    logic [MW-1:0] m_mag;
    logic          m_sat;
    sm_sum_t       add_res;

    sm_multiplier #(.N(N), .Q(Q)) u_mul (
        .a      (pe.x_in),
        .b      (pe.y_in),
        .p_sign (m_sign),
        .p_mag  (m_mag),
        .p_sat  (m_sat)
    );

    always_comb begin
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        vld_d      = pe.en;
        p_vld_d    = pe.en;
        p_sign_d   = p_sign_q;
        p_mag_d    = p_mag_q;
        p_sat_d    = p_sat_q;
        acc_sign_d = acc_sign_q;
        acc_mag_d  = acc_mag_q;
        ovf_d      = ovf_q;

        if (pe.en) begin
            x_out_d  = pe.x_in;
            y_out_d  = pe.y_in;
            p_sign_d = m_sign;
            p_mag_d  = m_mag;
            p_sat_d  = m_sat;
        end

        add_res = sm_add(acc_sign_q, SM_W'(acc_mag_q), p_sign_q, SM_W'(p_mag_q), MAX_SM);

        // clr wins over the in-flight product, which is dropped together with its saturation.
        if (pe.clr) begin
            acc_sign_d = 1'b0;
            acc_mag_d  = '0;
            ovf_d      = 1'b0;
        end else if (p_vld_q) begin
            acc_sign_d = add_res.sign;
            acc_mag_d  = add_res.mag[MW-1:0];
            // Upper working bits are zero after clamping; folding them in keeps any surprise visible.
            ovf_d      = ovf_q | p_sat_q | add_res.sat | (|add_res.mag[SM_W-1:MW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out_q    <= '0;
            y_out_q    <= '0;
            vld_q      <= 1'b0;
            p_vld_q    <= 1'b0;
            p_sign_q   <= 1'b0;
            p_mag_q    <= '0;
            p_sat_q    <= 1'b0;
            acc_sign_q <= 1'b0;
            acc_mag_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            vld_q      <= vld_d;
            p_vld_q    <= p_vld_d;
            p_sign_q   <= p_sign_d;
            p_mag_q    <= p_mag_d;
            p_sat_q    <= p_sat_d;
            acc_sign_q <= acc_sign_d;
            acc_mag_q  <= acc_mag_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pe.x_out   = x_out_q;
    assign pe.y_out   = y_out_q;
    assign pe.vld_out = vld_q;
    assign pe.acc_sum = {acc_sign_q, acc_mag_q};
    assign pe.ovf     = ovf_q;

endmodule

// File: tb/tb_pipelined_mac_pe.sv
// Directed plus randomized bench for pipelined_mac_pe against a signed-integer reference model.
module tb_pipelined_mac_pe;

    localparam int N = 32;
    localparam int Q = 10;
    localparam longint MAXM = (64'sd1 <<< (N - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_mac_pe_if #(.N(N)) pe_if ();

    pipelined_mac_pe #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pe    (pe_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: values held as plain signed integers in units of 2^-Q.
    longint       m_acc;
    bit           m_ovf;
    bit           m_pv;
    longint       m_p;
    bit           m_psat;
    logic [N-1:0] m_xo, m_yo;
    bit           m_vo;

    int t1a[4] = '{1, 3, 5, 7};
    int t1b[4] = '{2, 2, 5, 4};
    int t2a[4] = '{5, 2, -3, -2};
    int t2b[4] = '{8, 3, 4, -2};
    int t3a[4] = '{-1, 5, 2, 5};
    int t3b[4] = '{-1, -8, -3, 10};

    function automatic logic [N-1:0] sm(input int k);
        logic [N-1:0] r;
        int a;
        a = (k < 0) ? -k : k;
        r = '0;
        r[N-2:0] = (N-1)'(a) << Q;
        r[N-1] = (k < 0);
        return r;
    endfunction

    function automatic logic [N-1:0] int2sm(input longint v);
        if (v < 0) return {1'b1, (N-1)'(-v)};
        return {1'b0, (N-1)'(v)};
    endfunction

    task automatic model_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                              output longint p, output bit sat);
        longint unsigned pm;
        pm = 64'(x[N-2:0]) * 64'(y[N-2:0]);
`ifdef PE_ROUND_EN
        pm = pm + (64'd1 << (Q - 1));
`endif
        pm = pm >> Q;
        sat = (pm > 64'(MAXM));
        if (sat) pm = 64'(MAXM);
        p = (x[N-1] ^ y[N-1]) ? -longint'(pm) : longint'(pm);
    endtask

    task automatic model_reset();
        m_acc = 0; m_ovf = 0; m_pv = 0; m_p = 0; m_psat = 0;
        m_xo = '0; m_yo = '0; m_vo = 0;
    endtask

    task automatic model_edge(input bit e, input bit c, input logic [N-1:0] x, input logic [N-1:0] y);
        longint s;
        if (c) begin
            m_acc = 0;
            m_ovf = 0;
        end else if (m_pv) begin
            s = m_acc + m_p;
            if (s > MAXM) begin s = MAXM; m_ovf = 1; end
            if (s < -MAXM) begin s = -MAXM; m_ovf = 1; end
            if (m_psat) m_ovf = 1;
            m_acc = s;
        end
        if (e) begin
            m_xo = x; m_yo = y; m_vo = 1; m_pv = 1;
            model_prod(x, y, m_p, m_psat);
        end else begin
            m_vo = 0; m_pv = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x_out"},   pe_if.x_out,        m_xo);
        chk({tag, ".y_out"},   pe_if.y_out,        m_yo);
        chk({tag, ".vld_out"}, N'(pe_if.vld_out),  N'(m_vo));
        chk({tag, ".acc_sum"}, pe_if.acc_sum,      int2sm(m_acc));
        chk({tag, ".ovf"},     N'(pe_if.ovf),      N'(m_ovf));
    endtask

    task automatic cyc(input bit e, input bit c, input logic [N-1:0] x, input logic [N-1:0] y,
                       input string tag);
        pe_if.en = e; pe_if.clr = c; pe_if.x_in = x; pe_if.y_in = y;
        @(posedge clk);
        model_edge(e, c, x, y);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, tag);
    endtask

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] r;
        r = '0;
        if ($urandom_range(0, 7) == 0) r[N-2:0] = (N-1)'($urandom());
        else r[N-2:0] = (N-1)'(($urandom_range(0, 15) << Q) | $urandom_range(0, (1 << Q) - 1));
        r[N-1] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rexp;
        rst_n = 1'b0;
        pe_if.en = 1'b0; pe_if.clr = 1'b0; pe_if.x_in = '0; pe_if.y_in = '0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, sm(t1a[i]), sm(t1b[i]), "t1_pulse");
            cyc(1'b0, 1'b0, '0, '0, "t1_gap");
        end
        idle(2, "t1_idle");
        chk("t1_final", pe_if.acc_sum, 32'h0000F400);

        cyc(1'b0, 1'b1, '0, '0, "t2_clr");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, sm(t2a[i]), sm(t2b[i]), "t2");
        idle(2, "t2_idle");
        chk("t2_final", pe_if.acc_sum, sm(38));

        cyc(1'b0, 1'b1, '0, '0, "t3_clr");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, sm(t3a[i]), sm(t3b[i]), "t3");
        idle(2, "t3_idle");
        chk("t3_final", pe_if.acc_sum, sm(5));

        cyc(1'b0, 1'b1, '0, '0, "frac_clr");
        cyc(1'b1, 1'b0, 32'h00000200, 32'h00000200, "frac_half");
        idle(2, "frac_idle");
        chk("frac_half_sq", pe_if.acc_sum, 32'h00000100);
        cyc(1'b1, 1'b0, 32'h00000100, 32'h00000600, "frac_q15");
        idle(2, "frac_idle");
        chk("frac_accum", pe_if.acc_sum, 32'h00000280);

        cyc(1'b0, 1'b1, '0, '0, "rnd_clr");
        cyc(1'b1, 1'b0, 32'h00000001, 32'h00000200, "rnd");
        idle(2, "rnd_idle");
`ifdef PE_ROUND_EN
        rexp = 32'h00000001;
`else
        rexp = 32'h00000000;
`endif
        chk("round_lsb", pe_if.acc_sum, rexp);

        cyc(1'b0, 1'b1, '0, '0, "sat_clr");
        cyc(1'b1, 1'b0, 32'h7FFFFFFF, sm(2), "sat");
        idle(1, "sat_idle");
        chk("sat_acc", pe_if.acc_sum, 32'h7FFFFFFF);
        chk("sat_ovf", N'(pe_if.ovf), N'(1));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, sm(1), sm(1), "sat_hold");
        idle(2, "sat_idle");
        chk("sat_ovf_held", N'(pe_if.ovf), N'(1));
        cyc(1'b0, 1'b1, '0, '0, "sat_clr2");
        chk("ovf_cleared", N'(pe_if.ovf), N'(0));

        cyc(1'b1, 1'b0, sm(3), sm(2), "zero_a");
        cyc(1'b1, 1'b0, sm(-3), sm(2), "zero_b");
        idle(2, "zero_idle");
        chk("pos_zero", pe_if.acc_sum, 32'h00000000);

        cyc(1'b0, 1'b1, '0, '0, "b2b_clr");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, sm(t1a[i]), sm(t1b[i]), "b2b");
        idle(2, "b2b_idle");
        chk("b2b_final", pe_if.acc_sum, sm(61));

        cyc(1'b0, 1'b1, '0, '0, "mclr_clr");
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 2), sm(t1a[i]), sm(t1b[i]), "mclr");
        idle(2, "mclr_idle");
        chk("mid_clr_final", pe_if.acc_sum, sm(53));

        cyc(1'b0, 1'b1, '0, '0, "rand_clr");
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_op(), rand_op(), "rand");
        idle(2, "rand_idle");

        cyc(1'b1, 1'b0, sm(2), sm(3), "rst_a");
        pe_if.en = 1'b1; pe_if.x_in = sm(4); pe_if.y_in = sm(5);
        @(posedge clk);
        model_edge(1'b1, 1'b0, sm(4), sm(5));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        pe_if.en = 1'b0;
        rst_n = 1'b1;
        idle(3, "post_rst");
        chk("post_rst_acc", pe_if.acc_sum, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
